// File: rtl/cache_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : cache_pkg                                              |
// | Description : Shared widths, request record and sequencer states for |
// |               the CPU-side cache request path.                       |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
package cache_pkg;

    localparam int c_ADDR_WIDTH = 11;
    localparam int c_DATA_WIDTH = 8;

    typedef struct packed {
        logic                    write;
        logic [c_ADDR_WIDTH-1:0] addr;
        logic [c_DATA_WIDTH-1:0] wdata;
    } cpu_req_t;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/req_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : req_fifo                                               |
// | Description : Synchronous FIFO of cpu_req_t with wrap-bit pointers.  |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module req_fifo
    import cache_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     i_push,
    input  cpu_req_t i_push_data,
    input  logic     i_pop,
    output cpu_req_t o_pop_data,
    output logic     o_full,
    output logic     o_empty
);

    localparam int c_PTR_W = $clog2(DEPTH);

    logic [c_PTR_W:0] r_wr_ptr;
    logic [c_PTR_W:0] r_rd_ptr;
    cpu_req_t         r_mem [DEPTH];
    logic             w_do_push;
    logic             w_do_pop;

    // Same index with differing wrap bits means every slot is occupied.
    assign o_full    = (r_wr_ptr[c_PTR_W] != r_rd_ptr[c_PTR_W]) &&
                       (r_wr_ptr[c_PTR_W-1:0] == r_rd_ptr[c_PTR_W-1:0]);
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_pop_data = r_mem[r_rd_ptr[c_PTR_W-1:0]];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + (c_PTR_W+1)'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (c_PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[c_PTR_W-1:0]] <= i_push_data;
    end

endmodule
`default_nettype wire

// File: rtl/cpu_req_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : cpu_req_sequencer                                      |
// | Description : Queues CPU requests and issues them one at a time to   |
// |               L1 over the strobe / cpu_ready handshake.              |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module cpu_req_sequencer
    import cache_pkg::*;
#(
    parameter int ADDR_WIDTH = c_ADDR_WIDTH,
    parameter int DATA_WIDTH = c_DATA_WIDTH,
    parameter int DEPTH      = 4,
    parameter int LAT_WIDTH  = 8,
    parameter int TIMEOUT    = 200
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic                  rsp_write,
    output logic [ADDR_WIDTH-1:0] rsp_addr,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_timeout,
    output logic [LAT_WIDTH-1:0]  rsp_latency,
    output logic [ADDR_WIDTH-1:0] cpu_addr,
    output logic [DATA_WIDTH-1:0] cpu_data_in,
    output logic                  cpu_read,
    output logic                  cpu_write,
    input  logic [DATA_WIDTH-1:0] cpu_data_out,
    input  logic                  cpu_ready,
    output logic                  busy,
    output logic [15:0]           req_count
);

    seq_state_t           r_state;
    logic [LAT_WIDTH-1:0] r_lat;
    logic                 r_write;
    cpu_req_t             w_push_req;
    cpu_req_t             w_head;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_pop;

    // The struct widths come from the package defaults; the top widths must match them.
    assign w_push_req = '{write: req_write, addr: req_addr, wdata: req_wdata};
    assign req_ready  = !w_full;
    assign w_pop      = (r_state == IDLE) && !w_empty;
    assign busy       = !w_empty || (r_state == ACCESS);

    req_fifo #(
        .DEPTH (DEPTH)
    ) u_req_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (req_valid),
        .i_push_data (w_push_req),
        .i_pop       (w_pop),
        .o_pop_data  (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_lat       <= '0;
            r_write     <= 1'b0;
            cpu_addr    <= '0;
            cpu_data_in <= '0;
            cpu_read    <= 1'b0;
            cpu_write   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_write   <= 1'b0;
            rsp_addr    <= '0;
            rsp_rdata   <= '0;
            rsp_timeout <= 1'b0;
            rsp_latency <= '0;
            req_count   <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (!w_empty) begin
                        cpu_addr    <= w_head.addr;
                        cpu_data_in <= w_head.wdata;
                        cpu_read    <= !w_head.write;
                        cpu_write   <= w_head.write;
                        r_write     <= w_head.write;
                        r_lat       <= LAT_WIDTH'(1);
                        r_state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cpu_ready) begin
                        rsp_valid   <= 1'b1;
                        rsp_write   <= r_write;
                        rsp_addr    <= cpu_addr;
                        rsp_rdata   <= r_write ? '0 : cpu_data_out;
                        rsp_timeout <= 1'b0;
                        rsp_latency <= r_lat;
                        cpu_read    <= 1'b0;
                        cpu_write   <= 1'b0;
                        req_count   <= req_count + 16'd1;
                        r_state     <= IDLE;
                    end else if (r_lat == LAT_WIDTH'(TIMEOUT)) begin
                        rsp_valid   <= 1'b1;
                        rsp_write   <= r_write;
                        rsp_addr    <= cpu_addr;
                        rsp_rdata   <= '0;
                        rsp_timeout <= 1'b1;
                        rsp_latency <= r_lat;
                        cpu_read    <= 1'b0;
                        cpu_write   <= 1'b0;
                        req_count   <= req_count + 16'd1;
                        r_state     <= IDLE;
                    end else begin
                        r_lat <= r_lat + LAT_WIDTH'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cpu_req_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_cpu_req_sequencer                                   |
// | Description : Scoreboard bench with a behavioural L1 responder.      |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module tb_cpu_req_sequencer;

    localparam int          c_TIMEOUT = 200;
    localparam logic [10:0] c_NEVER   = 11'h7FF;

    typedef struct {
        logic        write;
        logic [10:0] addr;
        logic [7:0]  rdata;
        logic        timeout;
        logic [7:0]  lat;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [10:0] req_addr;
    logic [7:0]  req_wdata;
    logic        rsp_valid;
    logic        rsp_write;
    logic [10:0] rsp_addr;
    logic [7:0]  rsp_rdata;
    logic        rsp_timeout;
    logic [7:0]  rsp_latency;
    logic [10:0] cpu_addr;
    logic [7:0]  cpu_data_in;
    logic        cpu_read;
    logic        cpu_write;
    logic [7:0]  cpu_data_out;
    logic        cpu_ready;
    logic        busy;
    logic [15:0] req_count;

    int          n_assert = 0;
    int          n_fail   = 0;
    int          n_rsp    = 0;
    logic [15:0] exp_count = '0;
    exp_t        sb[$];
    exp_t        got;

    int          l1_lat     = 1;
    logic        idle_noise = 1'b0;
    logic        gap_check  = 1'b0;
    int          strobe_cnt = 0;
    int          low_cnt    = 0;
    logic        had_prev   = 1'b0;
    int          lens[$];
    logic [10:0] l_addr;
    logic [7:0]  l_data;
    logic        l_rd;
    logic        l_wr;

    cpu_req_sequencer #(
        .ADDR_WIDTH (11),
        .DATA_WIDTH (8),
        .DEPTH      (4),
        .LAT_WIDTH  (8),
        .TIMEOUT    (c_TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_write    (rsp_write),
        .rsp_addr     (rsp_addr),
        .rsp_rdata    (rsp_rdata),
        .rsp_timeout  (rsp_timeout),
        .rsp_latency  (rsp_latency),
        .cpu_addr     (cpu_addr),
        .cpu_data_in  (cpu_data_in),
        .cpu_read     (cpu_read),
        .cpu_write    (cpu_write),
        .cpu_data_out (cpu_data_out),
        .cpu_ready    (cpu_ready),
        .busy         (busy),
        .req_count    (req_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] l1_data(input logic [10:0] a);
        return a[7:0] ^ 8'hA4;
    endfunction

    // L1 responder: ready after l1_lat strobe cycles, never for c_NEVER.
    always @(negedge clk) begin
        if (cpu_read || cpu_write) begin
            if (strobe_cnt == 0) begin
                l_addr = cpu_addr; l_data = cpu_data_in; l_rd = cpu_read; l_wr = cpu_write;
                n_assert++;
                if (cpu_read === cpu_write) begin
                    n_fail++;
                    $display("FAIL strobe_onehot: read=%b write=%b, required exactly one", cpu_read, cpu_write);
                end
                if (gap_check && had_prev) begin
                    n_assert++;
                    if (low_cnt != 1) begin
                        n_fail++;
                        $display("FAIL strobe_gap: low for %0d cycles, required 1", low_cnt);
                    end
                end
            end else begin
                n_assert++;
                if (cpu_addr !== l_addr || cpu_data_in !== l_data || cpu_read !== l_rd || cpu_write !== l_wr) begin
                    n_fail++;
                    $display("FAIL strobe_hold: addr=%h data=%h rd=%b wr=%b, required %h %h %b %b",
                             cpu_addr, cpu_data_in, cpu_read, cpu_write, l_addr, l_data, l_rd, l_wr);
                end
            end
            strobe_cnt++;
            low_cnt = 0;
            cpu_ready = (cpu_addr != c_NEVER) && (strobe_cnt == l1_lat);
            cpu_data_out = cpu_ready ? l1_data(cpu_addr) : 8'hEE;
        end else begin
            if (strobe_cnt != 0) begin
                lens.push_back(strobe_cnt);
                had_prev = 1'b1;
            end
            strobe_cnt = 0;
            low_cnt++;
            cpu_ready = idle_noise;
            cpu_data_out = 8'h5A;
        end
    end

    // Response monitor against the scoreboard.
    always @(negedge clk) begin
        if (rst_n && rsp_valid) begin
            n_assert++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL rsp_unexpected: addr=%h, required no response", rsp_addr);
            end else begin
                got = sb.pop_front();
                if (rsp_write !== got.write || rsp_addr !== got.addr || rsp_rdata !== got.rdata ||
                    rsp_timeout !== got.timeout || rsp_latency !== got.lat) begin
                    n_fail++;
                    $display("FAIL rsp_fields: w=%b a=%h d=%h to=%b lat=%0d, required w=%b a=%h d=%h to=%b lat=%0d",
                             rsp_write, rsp_addr, rsp_rdata, rsp_timeout, rsp_latency,
                             got.write, got.addr, got.rdata, got.timeout, got.lat);
                end
            end
            n_rsp++;
            exp_count++;
            n_assert++;
            if (req_count !== exp_count) begin
                n_fail++;
                $display("FAIL req_count: %0d, required %0d", req_count, exp_count);
            end
        end
    end

    task automatic push(input logic wr, input logic [10:0] addr, input logic [7:0] wd);
        int   t;
        int   lat;
        exp_t e;
        t = 0;
        while (!req_ready && t < 1000) begin
            @(negedge clk);
            t++;
        end
        n_assert++;
        if (!req_ready) begin
            n_fail++;
            $display("FAIL push_ready_wait: req_ready=%b, required 1 within 1000 cycles", req_ready);
        end
        lat       = (addr == c_NEVER) ? 0 : l1_lat;
        e.write   = wr;
        e.addr    = addr;
        e.timeout = (lat == 0);
        e.rdata   = (wr || lat == 0) ? 8'h00 : l1_data(addr);
        e.lat     = (lat == 0) ? 8'(c_TIMEOUT) : 8'(lat);
        sb.push_back(e);
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((busy || sb.size() != 0) && t < 5000) begin
            @(negedge clk);
            t++;
        end
        n_assert++;
        if (busy || sb.size() != 0) begin
            n_fail++;
            $display("FAIL wait_idle: busy=%b pending=%0d, required idle", busy, sb.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        repeat (3) @(negedge clk);
        n_assert++;
        if (req_ready !== 1'b1 || busy !== 1'b0 || rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: ready=%b busy=%b rsp_valid=%b, required 1 0 0", req_ready, busy, rsp_valid);
        end
        n_assert++;
        if (cpu_read !== 1'b0 || cpu_write !== 1'b0 || cpu_addr !== 11'h0 || cpu_data_in !== 8'h0) begin
            n_fail++;
            $display("FAIL reset_cpu: rd=%b wr=%b addr=%h data=%h, required all 0", cpu_read, cpu_write, cpu_addr, cpu_data_in);
        end
        n_assert++;
        if (req_count !== 16'h0 || rsp_latency !== 8'h0 || rsp_rdata !== 8'h0) begin
            n_fail++;
            $display("FAIL reset_rsp: count=%0d lat=%0d rdata=%h, required 0", req_count, rsp_latency, rsp_rdata);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_read_miss();
        lens.delete();
        l1_lat = 12;
        push(1'b0, 11'h001, 8'h00);
        wait_idle();
        n_assert++;
        if (lens.size() != 1 || lens[0] != 12) begin
            n_fail++;
            $display("FAIL read_miss_strobe_len: %0d strobes, first len %0d, required 1 of 12",
                     lens.size(), (lens.size() != 0) ? lens[0] : -1);
        end
        n_assert++;
        if (req_count !== 16'd1) begin
            n_fail++;
            $display("FAIL read_miss_count: %0d, required 1", req_count);
        end
    endtask

    task automatic test_back_to_back();
        logic [10:0] addrs [4];
        addrs[0] = 11'h000; addrs[1] = 11'h002; addrs[2] = 11'h005; addrs[3] = 11'h010;
        l1_lat = 1;
        had_prev = 1'b0;
        gap_check = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_assert++;
            if (req_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_ready: push %0d saw req_ready=%b, required 1", i, req_ready);
            end
            push(1'b0, addrs[i], 8'h00);
        end
        wait_idle();
        gap_check = 1'b0;
    endtask

    task automatic test_full();
        int base;
        int t;
        l1_lat = 50;
        base = n_rsp;
        for (int i = 0; i < 5; i++) push(1'b0, 11'(11'h020 + i), 8'h00);
        n_assert++;
        if (req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL full_ready: req_ready=%b with 4 queued, required 0", req_ready);
        end
        t = 0;
        while (!req_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        n_assert++;
        if (n_rsp != base + 1) begin
            n_fail++;
            $display("FAIL full_release: %0d responses when space freed, required %0d", n_rsp - base, 1);
        end
        push(1'b0, 11'h025, 8'h00);
        wait_idle();
        n_assert++;
        if (n_rsp != base + 6) begin
            n_fail++;
            $display("FAIL full_total: %0d responses, required 6", n_rsp - base);
        end
    endtask

    task automatic test_write();
        int t;
        l1_lat = 3;
        idle_noise = 1'b1;
        push(1'b1, 11'h101, 8'h3C);
        t = 0;
        while (!(cpu_read || cpu_write) && t < 20) begin
            @(negedge clk);
            t++;
        end
        n_assert++;
        if (cpu_write !== 1'b1 || cpu_read !== 1'b0 || cpu_data_in !== 8'h3C || cpu_addr !== 11'h101) begin
            n_fail++;
            $display("FAIL write_drive: wr=%b rd=%b data=%h addr=%h, required 1 0 3c 101",
                     cpu_write, cpu_read, cpu_data_in, cpu_addr);
        end
        wait_idle();
        idle_noise = 1'b0;
    endtask

    task automatic test_timeout();
        lens.delete();
        l1_lat = 2;
        push(1'b0, c_NEVER, 8'h00);
        push(1'b0, 11'h033, 8'h00);
        wait_idle();
        n_assert++;
        if (lens.size() != 2 || lens[0] != c_TIMEOUT || lens[1] != 2) begin
            n_fail++;
            $display("FAIL timeout_strobe_len: %0d strobes, lens %0d/%0d, required 200/2", lens.size(),
                     (lens.size() > 0) ? lens[0] : -1, (lens.size() > 1) ? lens[1] : -1);
        end
    endtask

    task automatic test_reset_mid();
        int base;
        l1_lat = 50;
        push(1'b0, 11'h040, 8'h00);
        push(1'b1, 11'h041, 8'h11);
        push(1'b0, 11'h042, 8'h00);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        sb.delete();
        exp_count = '0;
        base = n_rsp;
        @(posedge clk);
        #1;
        n_assert++;
        if (cpu_read !== 1'b0 || cpu_write !== 1'b0 || rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_strobe: rd=%b wr=%b rsp_valid=%b, required 0", cpu_read, cpu_write, rsp_valid);
        end
        n_assert++;
        if (req_ready !== 1'b1 || busy !== 1'b0 || req_count !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_mid_state: ready=%b busy=%b count=%0d, required 1 0 0", req_ready, busy, req_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        n_assert++;
        if (n_rsp != base) begin
            n_fail++;
            $display("FAIL reset_mid_drop: %0d responses after reset, required 0", n_rsp - base);
        end
        l1_lat = 2;
        push(1'b0, 11'h044, 8'h00);
        wait_idle();
        n_assert++;
        if (req_count !== 16'd1) begin
            n_fail++;
            $display("FAIL reset_mid_recover: count=%0d, required 1", req_count);
        end
    endtask

    initial begin
        cpu_ready = 1'b0;
        cpu_data_out = 8'h00;
        test_reset();
        test_read_miss();
        test_back_to_back();
        test_full();
        test_write();
        test_timeout();
        test_reset_mid();
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/cpu_req_sequencer.md
Name: cpu_req_sequencer

Overview:
CPU-side request sequencer that sits directly upstream of L1_cache and drives its cpu_* port group. It buffers CPU read/write requests in a small FIFO and issues them one at a time using the L1 level-strobe / cpu_ready handshake. It returns one response per request with read data, measured latency and a timeout flag. It replaces hand-written task stimulus in cache benches and serves as the CPU front end in the integrated L1/L2/memory hierarchy.

Parameters:
ADDR_WIDTH, 11, byte address width (matches L1/L2/memory)
DATA_WIDTH, 8, CPU word width
DEPTH, 4, request FIFO entries; power of 2, minimum 2
LAT_WIDTH, 8, width of latency counter and rsp_latency
TIMEOUT, 200, cycles of strobe without cpu_ready before abort; must be less than 2**LAT_WIDTH

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
req_valid  in  1  request offered
req_ready  out  1  FIFO can accept (not full)
req_write  in  1  1=write, 0=read
req_addr  in  ADDR_WIDTH  request address
req_wdata  in  DATA_WIDTH  write data
rsp_valid  out  1  one-cycle response pulse
rsp_write  out  1  echoed request type
rsp_addr  out  ADDR_WIDTH  echoed request address
rsp_rdata  out  DATA_WIDTH  read data (0 for writes and timeouts)
rsp_timeout  out  1  access aborted by timeout
rsp_latency  out  LAT_WIDTH  cycles strobe was high, including the cpu_ready cycle
cpu_addr  out  ADDR_WIDTH  to L1 cpu_addr
cpu_data_in  out  DATA_WIDTH  to L1 cpu_data_in
cpu_read  out  1  to L1 cpu_read
cpu_write  out  1  to L1 cpu_write
cpu_data_out  in  DATA_WIDTH  from L1
cpu_ready  in  1  from L1; access complete
busy  out  1  FIFO non-empty or access in flight
req_count  out  16  completed responses since reset; wraps at 2**16

Behaviour:
- Reset (rst_n=0 at posedge): FIFO emptied; FSM=IDLE. All outputs go to 0 except req_ready=1. req_count=0. Reset mid-access drops the strobes at that edge; the in-flight request and queued requests are discarded with no response.
- Enqueue: on posedge with req_valid && req_ready. req_ready = !full, derived from registered pointers. When full, a push is rejected even if a pop occurs in the same cycle. Pointers are DEPTH-wrapping with an extra wrap bit for the full/empty distinction.
- FSM state IDLE: strobes low. If FIFO is non-empty at the posedge, pop the head into the issue registers. Drive cpu_addr and cpu_data_in, assert cpu_read or cpu_write (exactly one) from that edge, clear the latency counter to 1, and go to ACCESS.
- FSM state ACCESS: cpu_addr, cpu_data_in and the strobe are held stable. At each posedge:
  - If cpu_ready=1: capture cpu_data_out, or 0 for a write, into rsp_rdata. Pulse rsp_valid for one cycle with rsp_timeout=0 and rsp_latency=counter. Drop the strobe, increment req_count, and go to IDLE.
  - Else if counter==TIMEOUT: drop the strobe and pulse rsp_valid with rsp_timeout=1 and rsp_rdata=0. Increment req_count and go to IDLE.
  - Else: increment the counter.
- Minimum latency: request accepted at edge E0 into an empty FIFO with FSM IDLE gives strobe high after E1. If cpu_ready=1 is sampled at E2, rsp_valid is high after E2 with rsp_latency=1.
- Back-to-back: after a completion edge the strobes stay low for exactly one cycle (IDLE) before the next issue. L1 therefore always sees a deasserted strobe between requests.
- Requests are issued and responses returned strictly in FIFO order. There is no response backpressure; the consumer must sample rsp_valid.
- cpu_ready while in IDLE is ignored.
- busy = FIFO non-empty OR state==ACCESS.

Decomposition:
- Shared package cache_pkg holds:
  - ADDR_WIDTH/DATA_WIDTH defaults.
  - Packed typedef cpu_req_t {write, addr, wdata}.
  - Enum seq_state_t {IDLE, ACCESS}.
- Sub-module req_fifo: parameterised synchronous FIFO of cpu_req_t with push/pop/full/empty. The sequencer instantiates it once.

Test Plan:
- Read miss: push read 0x001; L1 model asserts cpu_ready 12 cycles after strobe with data 0xA5 -> cpu_read held with cpu_addr=0x001 for 12 cycles; rsp_valid pulse with rdata=0xA5, latency=12, timeout=0; req_count=1.
- Back-to-back hits: push reads 0x000, 0x002, 0x005, 0x010 on consecutive cycles; cpu_ready on the first strobe cycle -> four in-order responses, each latency=1; strobe low exactly one cycle between accesses; req_ready stays high.
- Full/backpressure: DEPTH=4, L1 stalled 50 cycles; offer 6 requests -> first in flight plus 4 queued accepted; 6th sees req_ready=0 until the first completion; no request lost or duplicated.
- Write: push write 0x101 data 0x3C -> cpu_write=1, cpu_read=0, cpu_data_in=0x3C; response rsp_write=1, rdata=0.
- Timeout: L1 never asserts cpu_ready -> strobe drops after TIMEOUT cycles; rsp_timeout=1, latency=200; next queued request issues normally.
- Reset mid-access: assert rst_n=0 during ACCESS with 2 queued -> strobes low at the next edge; no rsp_valid; req_ready=1; busy=0; req_count=0.
